// File: rtl/nv_nvdla_rt_csb_pipe.sv
`default_nettype none
// ============================================================================
// Module   : nv_nvdla_rt_csb_pipe
// Purpose  : CSB retiming pipe between the CSB master and a unit's CSB slave.
//            The request path is a chain of skid-buffered stages that honours
//            downstream backpressure. The response path is a valid-only delay
//            line. Response-expecting requests are counted so the block can
//            report idle and flag protocol violations.
// Ports    :
//   nvdla_core_clk   core clock
//   nvdla_core_rstn  synchronous active-low reset
//   req_src_*        upstream request handshake and payload
//   req_dst_*        downstream request handshake and payload
//   resp_src_*       response from the slave (no backpressure)
//   resp_dst_*       delayed response towards the master
//   outs_cnt         outstanding response-expecting requests
//   idle             nothing in flight and outs_cnt == 0
//   err              sticky counter over/underflow flag
// Revision : 1.0  initial release
// ============================================================================
module nv_nvdla_rt_csb_pipe #(
  parameter int REQ_W       = 63,
  parameter int RESP_W      = 34,
  parameter int REQ_STAGES  = 3,
  parameter int RESP_STAGES = 3,
  parameter int WR_BIT      = 54,
  parameter int NP_BIT      = 55,
  parameter int CNT_W       = 4
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              req_src_pvld,
  output logic              req_src_prdy,
  input  logic [REQ_W-1:0]  req_src_pd,
  output logic              req_dst_pvld,
  input  logic              req_dst_prdy,
  output logic [REQ_W-1:0]  req_dst_pd,
  input  logic              resp_src_valid,
  input  logic [RESP_W-1:0] resp_src_pd,
  output logic              resp_dst_valid,
  output logic [RESP_W-1:0] resp_dst_pd,
  output logic [CNT_W-1:0]  outs_cnt,
  output logic              idle,
  output logic              err
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // Request path. Index i of the chain vectors is the input side of stage i;
  // index REQ_STAGES is the downstream port, so zero stages collapses to a
  // plain combinational passthrough.
  // --------------------------------------------------------------------------
  logic [REQ_STAGES:0] w_req_vld;
  logic [REQ_STAGES:0] w_req_rdy;
  logic [REQ_W-1:0]    w_req_pd [REQ_STAGES+1];
  logic [REQ_STAGES:0] w_req_busy;

  assign w_req_vld[0]          = req_src_pvld;
  assign w_req_pd[0]           = req_src_pd;
  assign req_src_prdy          = w_req_rdy[0];
  assign req_dst_pvld          = w_req_vld[REQ_STAGES];
  assign req_dst_pd            = w_req_pd[REQ_STAGES];
  assign w_req_rdy[REQ_STAGES] = req_dst_prdy;
  assign w_req_busy[REQ_STAGES] = 1'b0;

  for (genvar i = 0; i < REQ_STAGES; i++) begin : g_req_stage
    logic             r_main_vld;
    logic             r_skid_vld;
    logic [REQ_W-1:0] r_main_pd;
    logic [REQ_W-1:0] r_skid_pd;
    logic             w_acc;
    logic             w_take;

    // Ready comes straight from the skid flop, which breaks the ready path
    // between stages.
    assign w_acc  = w_req_vld[i] & ~r_skid_vld;
    assign w_take = r_main_vld & w_req_rdy[i+1];

    always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
        r_main_vld <= 1'b0;
        r_skid_vld <= 1'b0;
      end else if (w_take) begin
        if (r_skid_vld) begin
          // Skid refills main; no accept is possible while skid is full.
          r_main_vld <= 1'b1;
          r_skid_vld <= 1'b0;
        end else begin
          r_main_vld <= w_acc;
        end
      end else if (w_acc) begin
        if (r_main_vld) begin
          r_skid_vld <= 1'b1;
        end else begin
          r_main_vld <= 1'b1;
        end
      end
    end

    always_ff @(posedge nvdla_core_clk) begin
      if (w_take) begin
        if (r_skid_vld) begin
          r_main_pd <= r_skid_pd;
        end else if (w_acc) begin
          r_main_pd <= w_req_pd[i];
        end
      end else if (w_acc) begin
        if (r_main_vld) begin
          r_skid_pd <= w_req_pd[i];
        end else begin
          r_main_pd <= w_req_pd[i];
        end
      end
    end

    assign w_req_rdy[i]   = ~r_skid_vld;
    assign w_req_vld[i+1] = r_main_vld;
    assign w_req_pd[i+1]  = r_main_pd;
    assign w_req_busy[i]  = r_main_vld | r_skid_vld;
  end

  // --------------------------------------------------------------------------
  // Response path: valid-only delay line, payload captured only alongside a
  // valid so idle cycles do not toggle the wide data flops.
  // --------------------------------------------------------------------------
  logic [RESP_STAGES:0] w_resp_vld;
  logic [RESP_W-1:0]    w_resp_pd [RESP_STAGES+1];
  logic [RESP_STAGES:0] w_resp_busy;

  assign w_resp_vld[0]            = resp_src_valid;
  assign w_resp_pd[0]             = resp_src_pd;
  assign resp_dst_valid           = w_resp_vld[RESP_STAGES];
  assign resp_dst_pd              = w_resp_pd[RESP_STAGES];
  assign w_resp_busy[RESP_STAGES] = 1'b0;

  for (genvar j = 0; j < RESP_STAGES; j++) begin : g_resp_stage
    logic              r_vld;
    logic [RESP_W-1:0] r_pd;

    always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
        r_vld <= 1'b0;
      end else begin
        r_vld <= w_resp_vld[j];
      end
    end

    always_ff @(posedge nvdla_core_clk) begin
      if (w_resp_vld[j]) begin
        r_pd <= w_resp_pd[j];
      end
    end

    assign w_resp_vld[j+1] = r_vld;
    assign w_resp_pd[j+1]  = r_pd;
    assign w_resp_busy[j]  = r_vld;
  end

  // --------------------------------------------------------------------------
  // Outstanding counter: reads and non-posted writes expect a response.
  // --------------------------------------------------------------------------
  logic             w_inc;
  logic             w_dec;
  logic [CNT_W-1:0] r_outs_cnt;
  logic             r_err;

  assign w_inc = req_dst_pvld & req_dst_prdy &
                 (~req_dst_pd[WR_BIT] | req_dst_pd[NP_BIT]);
  assign w_dec = resp_dst_valid;

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_outs_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_inc && !w_dec) begin
      if (r_outs_cnt == c_cnt_max) begin
        r_err <= 1'b1;
      end else begin
        r_outs_cnt <= r_outs_cnt + CNT_W'(1);
      end
    end else if (w_dec && !w_inc) begin
      if (r_outs_cnt == '0) begin
        r_err <= 1'b1;
      end else begin
        r_outs_cnt <= r_outs_cnt - CNT_W'(1);
      end
    end
  end

  assign outs_cnt = r_outs_cnt;
  assign err      = r_err;
  assign idle     = ~(|w_req_busy) & ~(|w_resp_busy) & (r_outs_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_rt_csb_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_nv_nvdla_rt_csb_pipe
// Purpose  : Self-checking bench for nv_nvdla_rt_csb_pipe with a scoreboard
//            for both paths and a reference model of the outstanding counter.
// Revision : 1.0  initial release
// ============================================================================
module tb_nv_nvdla_rt_csb_pipe;

  localparam int REQ_W       = 63;
  localparam int RESP_W      = 34;
  localparam int REQ_STAGES  = 3;
  localparam int RESP_STAGES = 3;
  localparam int WR_BIT      = 54;
  localparam int NP_BIT      = 55;
  localparam int CNT_W       = 4;
  localparam int c_cnt_max   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rstn;
  logic              req_src_pvld;
  logic              req_src_prdy;
  logic [REQ_W-1:0]  req_src_pd;
  logic              req_dst_pvld;
  logic              req_dst_prdy;
  logic [REQ_W-1:0]  req_dst_pd;
  logic              resp_src_valid;
  logic [RESP_W-1:0] resp_src_pd;
  logic              resp_dst_valid;
  logic [RESP_W-1:0] resp_dst_pd;
  logic [CNT_W-1:0]  outs_cnt;
  logic              idle;
  logic              err;

  nv_nvdla_rt_csb_pipe #(
    .REQ_W(REQ_W), .RESP_W(RESP_W), .REQ_STAGES(REQ_STAGES),
    .RESP_STAGES(RESP_STAGES), .WR_BIT(WR_BIT), .NP_BIT(NP_BIT), .CNT_W(CNT_W)
  ) u_dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .req_src_pvld   (req_src_pvld),
    .req_src_prdy   (req_src_prdy),
    .req_src_pd     (req_src_pd),
    .req_dst_pvld   (req_dst_pvld),
    .req_dst_prdy   (req_dst_prdy),
    .req_dst_pd     (req_dst_pd),
    .resp_src_valid (resp_src_valid),
    .resp_src_pd    (resp_src_pd),
    .resp_dst_valid (resp_dst_valid),
    .resp_dst_pd    (resp_dst_pd),
    .outs_cnt       (outs_cnt),
    .idle           (idle),
    .err            (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // --------------------------------------------------------------------------
  // Scoreboard and counter model, evaluated mid-cycle. Inputs change just
  // after the rising edge, so what is seen here is what the next edge samples.
  // --------------------------------------------------------------------------
  typedef struct {
    int                due;
    logic [RESP_W-1:0] pd;
  } resp_t;

  logic [REQ_W-1:0] req_q[$];
  resp_t            resp_q[$];
  int               m_cnt = 0;
  bit               m_err = 1'b0;
  bit               mon_en = 1'b0;
  int               n_req_out = 0;

  always @(negedge clk) begin
    logic [REQ_W-1:0] e;
    resp_t            r;
    bit               inc;
    bit               dec;
    inc = 1'b0;
    dec = 1'b0;
    if (mon_en) begin
      chk("mdl_cnt", 64'(outs_cnt), 64'(m_cnt));
      chk("mdl_err", 64'(err), 64'(m_err));
    end
    if (!rstn) begin
      req_q.delete();
      resp_q.delete();
      m_cnt = 0;
      m_err = 1'b0;
    end else if (mon_en) begin
      if (req_src_pvld && req_src_prdy) req_q.push_back(req_src_pd);
      if (req_dst_pvld && req_dst_prdy) begin
        n_req_out++;
        if (req_q.size() == 0) begin
          chk("req_unexp", 64'(req_dst_pvld), 64'd0);
        end else begin
          e = req_q.pop_front();
          chk("req_pd", 64'(req_dst_pd), 64'(e));
          inc = !e[WR_BIT] || e[NP_BIT];
        end
      end
      if (resp_src_valid) resp_q.push_back('{cyc + RESP_STAGES, resp_src_pd});
      if (resp_q.size() != 0 && resp_q[0].due == cyc) begin
        r = resp_q.pop_front();
        dec = 1'b1;
        chk("resp_vld", 64'(resp_dst_valid), 64'd1);
        chk("resp_pd", 64'(resp_dst_pd), 64'(r.pd));
      end else begin
        chk("resp_vld", 64'(resp_dst_valid), 64'd0);
      end
      if (inc && !dec) begin
        if (m_cnt == c_cnt_max) m_err = 1'b1;
        else m_cnt++;
      end else if (dec && !inc) begin
        if (m_cnt == 0) m_err = 1'b1;
        else m_cnt--;
      end
    end
  end

  task automatic send(input logic [REQ_W-1:0] pd);
    chk("send_rdy", 64'(req_src_prdy), 64'd1);
    req_src_pvld = 1'b1;
    req_src_pd   = pd;
    step();
    req_src_pvld = 1'b0;
  endtask

  task automatic respond(input logic [RESP_W-1:0] pd);
    resp_src_valid = 1'b1;
    resp_src_pd    = pd;
    step();
    resp_src_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx;
    int  n0;
    bit  acc;

    rstn           = 1'b0;
    req_src_pvld   = 1'b0;
    req_src_pd     = '0;
    req_dst_prdy   = 1'b1;
    resp_src_valid = 1'b0;
    resp_src_pd    = '0;
    step(2);
    chk("rst_prdy", 64'(req_src_prdy), 64'd1);
    chk("rst_dvld", 64'(req_dst_pvld), 64'd0);
    chk("rst_rvld", 64'(resp_dst_valid), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_cnt", 64'(outs_cnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rstn   = 1'b1;
    mon_en = 1'b1;

    // Latency and back-to-back throughput (posted writes keep counter at 0).
    req_src_pvld = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      req_src_pd = (63'd1 << WR_BIT) | 63'(i);
      step();
      chk("t1_src_prdy", 64'(req_src_prdy), 64'd1);
    end
    req_src_pvld = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("t1_dst_vld", 64'(req_dst_pvld), 64'd1);
      chk("t1_dst_pd", 64'(req_dst_pd), 64'((63'd1 << WR_BIT) | 63'(i)));
      step();
    end
    chk("t1_dst_done", 64'(req_dst_pvld), 64'd0);
    step(2);

    // Backpressure: six beats absorbed, then ready drops.
    req_dst_prdy = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      req_src_pvld = 1'b1;
      req_src_pd   = (63'd1 << WR_BIT) | (63'h10 + 63'(idx));
      acc = req_src_prdy;
      step();
      if (acc) begin
        idx++;
        if (idx == 6) chk("t2_prdy_after6", 64'(req_src_prdy), 64'd0);
      end
    end
    chk("t2_accepted", 64'(idx), 64'd6);
    chk("t2_prdy_held", 64'(req_src_prdy), 64'd0);
    n0 = n_req_out;
    req_dst_prdy = 1'b1;
    for (int c = 0; c < 20 && idx < 8; c++) begin
      req_src_pvld = 1'b1;
      req_src_pd   = (63'd1 << WR_BIT) | (63'h10 + 63'(idx));
      acc = req_src_prdy;
      step();
      if (acc) idx++;
    end
    req_src_pvld = 1'b0;
    chk("t2_all_accepted", 64'(idx), 64'd8);
    step(12);
    chk("t2_delivered", 64'(n_req_out - n0), 64'd8);
    chk("t2_idle", 64'(idle), 64'd1);

    // Read request and its response.
    send('0);
    step(3);
    chk("t3_cnt1", 64'(outs_cnt), 64'd1);
    respond(34'h2_0000_00AB);
    step();
    chk("t3_rvld_early", 64'(resp_dst_valid), 64'd0);
    step();
    chk("t3_rvld", 64'(resp_dst_valid), 64'd1);
    chk("t3_rpd", 64'(resp_dst_pd), 64'h2_0000_00AB);
    step();
    chk("t3_cnt0", 64'(outs_cnt), 64'd0);
    chk("t3_idle", 64'(idle), 64'd1);

    // Posted write, non-posted write, matching and spurious responses.
    send(63'd1 << WR_BIT);
    step(5);
    chk("t4_posted", 64'(outs_cnt), 64'd0);
    send((63'd1 << WR_BIT) | (63'd1 << NP_BIT));
    step(5);
    chk("t4_np", 64'(outs_cnt), 64'd1);
    respond(34'h1_2345_6789);
    step(5);
    chk("t4_np_done", 64'(outs_cnt), 64'd0);
    chk("t4_np_err", 64'(err), 64'd0);
    respond(34'h0_0000_0055);
    step(5);
    chk("t4_spur_err", 64'(err), 64'd1);
    chk("t4_spur_cnt", 64'(outs_cnt), 64'd0);

    // Reset with traffic in flight on both paths.
    req_dst_prdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_src_pvld   = 1'b1;
      req_src_pd     = 63'h200 + 63'(i);
      resp_src_valid = (i >= 2);
      resp_src_pd    = 34'h300 + 34'(i);
      step();
    end
    req_src_pvld   = 1'b0;
    resp_src_valid = 1'b0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("t5_dvld", 64'(req_dst_pvld), 64'd0);
    chk("t5_rvld", 64'(resp_dst_valid), 64'd0);
    chk("t5_cnt", 64'(outs_cnt), 64'd0);
    chk("t5_err", 64'(err), 64'd0);
    chk("t5_prdy", 64'(req_src_prdy), 64'd1);
    chk("t5_idle", 64'(idle), 64'd1);
    req_dst_prdy = 1'b1;
    n0 = n_req_out;
    step(10);
    chk("t5_nothing_out", 64'(n_req_out - n0), 64'd0);

    // Counter saturation with simultaneous and lone increments.
    req_src_pvld = 1'b1;
    for (int i = 0; i < 15; i++) begin
      req_src_pd = 63'h100 + 63'(i);
      step();
    end
    req_src_pvld = 1'b0;
    step(6);
    chk("t6_cnt15", 64'(outs_cnt), 64'd15);
    chk("t6_err0", 64'(err), 64'd0);
    req_src_pvld   = 1'b1;
    req_src_pd     = 63'h300;
    resp_src_valid = 1'b1;
    resp_src_pd    = 34'h3_0000_0001;
    step();
    req_src_pvld   = 1'b0;
    resp_src_valid = 1'b0;
    step(6);
    chk("t6_same_cnt", 64'(outs_cnt), 64'd15);
    chk("t6_same_err", 64'(err), 64'd0);
    send(63'h301);
    step(6);
    chk("t6_sat_cnt", 64'(outs_cnt), 64'd15);
    chk("t6_sat_err", 64'(err), 64'd1);

    step(4);
    chk("end_req_q", 64'(req_q.size()), 64'd0);
    chk("end_resp_q", 64'(resp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
